// File: rtl/t02_bus_sram_responder.sv
// Bus-side SRAM responder: decodes a word-addressed window, serves single-word
// reads and byte-masked writes with programmable wait states, flags misses and
// illegal requests on err_o.
module t02_bus_sram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] cpu_dat_i,
    input  logic [3:0]  sel_i,
    output logic        busy_o,
    output logic [31:0] cpu_dat_o,
    output logic        err_o
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SPAN_B = 4 * DEPTH;
    // One bit wider than the bus so the window end cannot wrap.
    localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(SPAN_B);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        adr_q;
    logic [31:0]        dat_q;
    logic [3:0]         sel_q;
    logic               rd_q;
    logic               wr_q;

    logic [31:0]        mem [DEPTH];

    logic               hit_c;
    logic [31:0]        offset_c;
    logic [IDX_W-1:0]   idx_c;
    logic               complete_c;
    logic               illegal_c;

    // Window decode and word index of the latched request.
    always_comb begin
        hit_c      = (adr_q >= BASE_ADDR) && (33'(adr_q) < END_ADDR);
        offset_c   = adr_q - BASE_ADDR;
        idx_c      = IDX_W'(offset_c >> 2);
        complete_c = (state == ACCESS) && (cnt == '0);
        illegal_c  = rd_q && wr_q;
    end

    // Request FSM: accept a strobe in IDLE, count wait states, complete the access.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            cpu_dat_o <= 32'h0;
            err_o     <= 1'b0;
            cnt       <= '0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (read_i || write_i) begin
                        adr_q  <= adr_i;
                        dat_q  <= cpu_dat_i;
                        sel_q  <= sel_i;
                        rd_q   <= read_i;
                        wr_q   <= write_i;
                        busy_o <= 1'b1;
                        cnt    <= CNT_W'(WAIT_STATES);
                        state  <= ACCESS;
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                        if (illegal_c) begin
                            err_o <= 1'b1;
                        end else if (!hit_c) begin
                            err_o <= 1'b1;
                            if (rd_q) cpu_dat_o <= 32'h0;
                        end else if (rd_q) begin
                            cpu_dat_o <= mem[idx_c];
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Byte-masked write commit at completion; storage itself is never reset.
    always_ff @(posedge CLK) begin
        if (!RST && complete_c && wr_q && !rd_q && hit_c) begin
            for (int n = 0; n < 4; n++) begin
                if (sel_q[n]) mem[idx_c][8*n +: 8] <= dat_q[8*n +: 8];
            end
        end
    end

endmodule

// File: tb/tb_t02_bus_sram_responder.sv
// Bench for t02_bus_sram_responder: one instance with no wait states, one with three.
module tb_t02_bus_sram_responder;

    localparam logic [31:0] BASE  = 32'h3300_0000;
    localparam int          DEPTH = 1024;
    localparam int          WS [2] = '{0, 3};

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic [3:0]  sel  [2];
    logic        busy [2];
    logic [31:0] rdat [2];
    logic        err  [2];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mm [2][DEPTH];
    logic [31:0] exp_dat [2];

    always #5 CLK = ~CLK;

    t02_bus_sram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .CLK(CLK), .RST(RST), .read_i(rd[0]), .write_i(wr[0]), .adr_i(adr[0]),
        .cpu_dat_i(wdat[0]), .sel_i(sel[0]), .busy_o(busy[0]), .cpu_dat_o(rdat[0]),
        .err_o(err[0])
    );

    t02_bus_sram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(3)) dut1 (
        .CLK(CLK), .RST(RST), .read_i(rd[1]), .write_i(wr[1]), .adr_i(adr[1]),
        .cpu_dat_i(wdat[1]), .sel_i(sel[1]), .busy_o(busy[1]), .cpu_dat_o(rdat[1]),
        .err_o(err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference: apply one request to the model, return expected err.
    task automatic model_op(input int d, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] dt,
                            input logic [3:0] s, output logic e);
        longint la;
        int     idx;
        logic [31:0] word;
        la  = longint'(a);
        if (r && w) begin
            e = 1'b1;
        end else if (la < longint'(BASE) || la >= longint'(BASE) + 4 * DEPTH) begin
            e = 1'b1;
            if (r) exp_dat[d] = 32'h0;
        end else begin
            e   = 1'b0;
            idx = int'((la - longint'(BASE)) / 4);
            if (r) begin
                exp_dat[d] = mm[d][idx];
            end else begin
                word = mm[d][idx];
                for (int n = 0; n < 4; n++)
                    if (s[n]) word[8*n +: 8] = dt[8*n +: 8];
                mm[d][idx] = word;
            end
        end
    endtask

    // Issue one request on instance d and check timing, data and error pulse.
    task automatic access(input int d, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] dt,
                          input logic [3:0] s, input bit mid_strobe);
        logic e;
        int   nb;
        model_op(d, r, w, a, dt, s, e);
        @(negedge CLK);
        rd[d] = r; wr[d] = w; adr[d] = a; wdat[d] = dt; sel[d] = s;
        @(posedge CLK); #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
        nb = 0;
        while (busy[d] === 1'b1 && nb < 40) begin
            nb++;
            check("err_while_busy", 32'(err[d]), 32'h0);
            if (mid_strobe && nb == 2) begin
                rd[d] = 1'b1; adr[d] = BASE + 32'h8;
            end else begin
                rd[d] = 1'b0;
            end
            @(posedge CLK); #1;
        end
        rd[d] = 1'b0;
        check("busy_len", 32'(nb), 32'(WS[d] + 1));
        check("err_done", 32'(err[d]), 32'(e));
        check("rdat", rdat[d], exp_dat[d]);
        @(posedge CLK); #1;
        check("err_pulse_end", 32'(err[d]), 32'h0);
        check("idle_after", 32'(busy[d]), 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic        r, w;
        int          k;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b1; wr[d] = 1'b1; adr[d] = BASE; wdat[d] = 32'hFFFF_FFFF; sel[d] = 4'hF;
            exp_dat[d] = 32'h0;
        end

        // Reset with strobes asserted
        repeat (2) @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_busy", 32'(busy[d]), 32'h0);
            check("rst_dat", rdat[d], 32'h0);
            check("rst_err", 32'(err[d]), 32'h0);
            rd[d] = 1'b0; wr[d] = 1'b0;
        end
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;
        for (int d = 0; d < 2; d++) check("post_rst_busy", 32'(busy[d]), 32'h0);

        // Fill both memories so every word has a known value
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                access(d, 1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 1'b0);

        for (int d = 0; d < 2; d++) begin
            // Full write then read back
            access(d, 1'b0, 1'b1, 32'h3300_0010, 32'hCAFE_BABE, 4'hF, 1'b0);
            access(d, 1'b1, 1'b0, 32'h3300_0010, 32'h0, 4'h0, 1'b0);
            check("cafebabe", rdat[d], 32'hCAFE_BABE);
            // Byte mask
            access(d, 1'b0, 1'b1, 32'h3300_0020, 32'h1122_3344, 4'hF, 1'b0);
            access(d, 1'b0, 1'b1, 32'h3300_0020, 32'hAABB_CCDD, 4'b0101, 1'b0);
            access(d, 1'b0, 1'b1, 32'h3300_0020, 32'h5555_5555, 4'b0000, 1'b0);
            access(d, 1'b1, 1'b0, 32'h3300_0023, 32'h0, 4'h0, 1'b0);
            check("bytemask", rdat[d], 32'h11BB_33DD);
            // Window edges
            access(d, 1'b1, 1'b0, 32'h3300_0FFC, 32'h0, 4'hF, 1'b0);
            access(d, 1'b1, 1'b0, 32'h3300_1000, 32'h0, 4'hF, 1'b0);
            access(d, 1'b1, 1'b0, 32'h3300_0FFC, 32'h0, 4'hF, 1'b0);
            access(d, 1'b1, 1'b0, 32'h32FF_FFFC, 32'h0, 4'hF, 1'b0);
            access(d, 1'b0, 1'b1, 32'h3300_1000, 32'h1234_5678, 4'hF, 1'b0);
            // Illegal request leaves memory and read data untouched
            access(d, 1'b1, 1'b1, 32'h3300_0010, 32'h0BAD_0BAD, 4'hF, 1'b0);
            access(d, 1'b1, 1'b0, 32'h3300_0010, 32'h0, 4'h0, 1'b0);
            check("illegal_nochg", rdat[d], 32'hCAFE_BABE);
        end

        // Strobe during busy on the wait-state instance is ignored
        access(1, 1'b1, 1'b0, 32'h3300_0100, 32'h0, 4'h0, 1'b1);

        // Reset in the middle of a write
        @(negedge CLK);
        wr[1] = 1'b1; adr[1] = BASE + 32'h40; wdat[1] = 32'hDEAD_BEEF; sel[1] = 4'hF;
        @(posedge CLK); #1;
        wr[1] = 1'b0;
        check("midrst_busy_pre", 32'(busy[1]), 32'h1);
        @(negedge CLK); RST = 1'b1;
        @(posedge CLK); #1;
        check("midrst_busy", 32'(busy[1]), 32'h0);
        check("midrst_dat", rdat[1], 32'h0);
        exp_dat[0] = 32'h0; exp_dat[1] = 32'h0;
        @(negedge CLK); RST = 1'b0;
        repeat (5) @(posedge CLK);
        access(1, 1'b1, 1'b0, BASE + 32'h40, 32'h0, 4'h0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            for (int d = 0; d < 2; d++) begin
                k = int'($urandom_range(0, 9));
                if (k < 7)      a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
                else if (k == 7) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
                else if (k == 8) a = BASE - 32'($urandom_range(1, 8));
                else            a = $urandom;
                k = int'($urandom_range(0, 19));
                r = (k < 9) || (k == 19);
                w = (k >= 9);
                access(d, r, w, a, $urandom, 4'($urandom), 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
